whack_event_arbiter: RTL

Sits between the per-hole button inputs and mole generator and the combo counter. Classifies each press as a hit or a miss and detects full-clear hits. Merges press events with mole-expiry misses and serialises them through a small FIFO. Emits mutually exclusive single-cycle `miss`, `non_full_clear_hit` and `full_clear_hit` pulses, spaced so the combo counter never sees overlapping or merged events.

---
 rtl/whack_pkg.sv | 20 ++
 rtl/event_fifo.sv | 71 +++++++
 rtl/whack_event_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared types and defaults for the whack event arbiter
package whack_pkg;

    localparam int N_HOLES_DEF = 8;

    // Event codes carried through the event FIFO
    typedef enum logic [1:0] {
        EV_MISS = 2'd0,
        EV_HIT  = 2'd1,
        EV_FULL = 2'd2
    } ev_t;

    // Output sequencer states
    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } arb_state_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - 2-bit event FIFO with dual push and single pop
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push_a / data_a     first push of the cycle (stored ahead of push_b)
//   push_b / data_b     second push of the cycle
//   pop                 remove head (ignored when empty)
//   head                event at the head of the queue
//   full                no free slot
//   count               occupancy
//   drop                one-cycle pulse: at least one push did not fit
module event_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_a,
    input  logic [1:0]    data_a,
    input  logic          push_b,
    input  logic [1:0]    data_b,
    input  logic          pop,
    output logic [1:0]    head,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          drop
);

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW:0]   free;
    logic          do_pop;
    logic          acc_a;
    logic          acc_b;

    assign do_pop = pop && (count != '0);

    // A same-cycle pop frees its slot for the pushes of that cycle.
    assign free  = (CW+1)'(DEPTH) - {1'b0, count} + {{CW{1'b0}}, do_pop};
    assign acc_a = push_a && (free != '0);
    assign acc_b = push_b && (free > {{CW{1'b0}}, acc_a});
    assign drop  = (push_a && !acc_a) || (push_b && !acc_b);

    assign head = mem[rd_ptr];
    assign full = (count == CW'(DEPTH));

    // push_b lands right behind push_a, or at wr_ptr when push_a is absent
    always_ff @(posedge clk) begin
        if (acc_a) begin
            mem[wr_ptr] <= data_a;
        end
        if (acc_b) begin
            mem[wr_ptr + AW'(acc_a)] <= data_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(acc_a) + AW'(acc_b);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(acc_a) + CW'(acc_b) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/whack_event_arbiter.sv
// rtl/whack_event_arbiter.sv - classifies presses, queues events, emits spaced pulses
//
// Optional build macro: WHACK_ARB_LOCKOUT_EN (per-hole press lockout)
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   btn                   debounced buttons, active-high level
//   mole_up               holes currently showing a mole
//   mole_expired          one-cycle pulse per hole: mole timed out unhit
//   whack                 one-cycle pulse per hit hole (retract mole)
//   miss                  one-cycle miss event
//   non_full_clear_hit    one-cycle hit event, moles remain
//   full_clear_hit        one-cycle hit event that cleared every mole
//   overflow              sticky: an event was dropped
module whack_event_arbiter
    import whack_pkg::*;
#(
    parameter int N_HOLES        = N_HOLES_DEF,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_HOLES-1:0] btn,
    input  logic [N_HOLES-1:0] mole_up,
    input  logic [N_HOLES-1:0] mole_expired,
    output logic [N_HOLES-1:0] whack,
    output logic               miss,
    output logic               non_full_clear_hit,
    output logic               full_clear_hit,
    output logic               overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    logic [N_HOLES-1:0] btn_q;
    logic [N_HOLES-1:0] press_raw;
    logic [N_HOLES-1:0] press;
    logic [N_HOLES-1:0] hit_mask;
    logic               bad;
    logic               press_vld;
    ev_t                press_ev;
    logic               exp_vld;

    logic               pop;
    logic [1:0]         fifo_head;
    logic [CW-1:0]      fifo_count;
    logic               fifo_drop;
    logic               unused_fifo_full;

    arb_state_t         state, state_nxt;
    logic [GW-1:0]      gap_cnt, gap_nxt;
    logic               miss_nxt, hit_nxt, full_nxt;

    // btn_q starts all-ones so a button held through reset is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= '1;
        end else begin
            btn_q <= btn;
        end
    end

    assign press_raw = btn & ~btn_q;

`ifdef WHACK_ARB_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    logic [LW-1:0]      lock_cnt [N_HOLES];
    logic [N_HOLES-1:0] locked;

    always_comb begin
        for (int i = 0; i < N_HOLES; i++) begin
            locked[i] = (lock_cnt[i] != '0);
        end
    end

    assign press = press_raw & ~locked;

    // Any accepted press (hit or miss) re-arms that hole's lockout
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_HOLES; i++) begin
                lock_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_HOLES; i++) begin
                if (press[i]) begin
                    lock_cnt[i] <= LW'(LOCKOUT_CYCLES);
                end else if (locked[i]) begin
                    lock_cnt[i] <= lock_cnt[i] - 1'b1;
                end
            end
        end
    end
`else
    logic [31:0] unused_lockout;
    assign unused_lockout = LOCKOUT_CYCLES;
    assign press = press_raw;
`endif

    assign hit_mask = press & mole_up;
    assign bad      = |(press & ~mole_up);
    assign exp_vld  = |mole_expired;

    // A single wrong hole turns the whole cycle into a miss
    always_comb begin
        press_vld = 1'b0;
        press_ev  = EV_MISS;
        if (bad) begin
            press_vld = 1'b1;
            press_ev  = EV_MISS;
        end else if (hit_mask != '0) begin
            press_vld = 1'b1;
            press_ev  = ((mole_up & ~hit_mask) == '0) ? EV_FULL : EV_HIT;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_a (press_vld),
        .data_a (press_ev),
        .push_b (exp_vld),
        .data_b (EV_MISS),
        .pop    (pop),
        .head   (fifo_head),
        .full   (unused_fifo_full),
        .count  (fifo_count),
        .drop   (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            whack    <= '0;
            overflow <= 1'b0;
        end else begin
            whack <= hit_mask;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            gap_cnt            <= '0;
            miss               <= 1'b0;
            non_full_clear_hit <= 1'b0;
            full_clear_hit     <= 1'b0;
        end else begin
            state              <= state_nxt;
            gap_cnt            <= gap_nxt;
            miss               <= miss_nxt;
            non_full_clear_hit <= hit_nxt;
            full_clear_hit     <= full_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        pop       = 1'b0;
        miss_nxt  = 1'b0;
        hit_nxt   = 1'b0;
        full_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop       = 1'b1;
                    state_nxt = EMIT;
                    case (ev_t'(fifo_head))
                        EV_MISS: miss_nxt = 1'b1;
                        EV_HIT:  hit_nxt  = 1'b1;
                        EV_FULL: full_nxt = 1'b1;
                        default: ;
                    endcase
                end
            end
            EMIT: begin
                if (GAP_CYCLES == 0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt   = GW'(GAP_CYCLES);
                    state_nxt = GAP;
                end
            end
            GAP: begin
                gap_nxt = gap_cnt - 1'b1;
                if (gap_cnt <= GW'(1)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
